// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg -- shared definitions for the MMIO bridge.
//   state_e      : bridge FSM state encoding (IDLE / ACCESS / RESP)
//   ERR_DATA     : read data returned on any bus error (replicated to DATA_W)
//   ERR_REG_ADDR : address of the optional internal error register
//   CNT_W        : width of the ACCESS wait-cycle counter (TIMEOUT <= 255)
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA     = 32'hFFFF_FFFF;
    localparam logic [31:0] ERR_REG_ADDR = 32'hFFFF_F0F0;
    localparam int          CNT_W        = 8;

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode -- combinational address decoder.
//   addr_i : request address
//   sel_o  : one-hot slave select (lowest matching index wins), 0 on a miss
//   hit_o  : at least one slave matched
// Slave i matches when (addr_i & mask_i) == base_i, with base/mask taken from
// the flattened 32-bit-per-entry tables SLV_BASE / SLV_MASK.
module mmio_addr_decode
    import mmio_bridge_pkg::*;
#(
    parameter int                     NUM_SLV  = 5,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE = '0,
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK = '0
) (
    input  logic [31:0]        addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               hit_o
);

    logic [NUM_SLV-1:0] match;

    genvar g;
    for (g = 0; g < NUM_SLV; g++) begin : g_match
        assign match[g] = ((addr_i & SLV_MASK[g*32 +: 32]) == SLV_BASE[g*32 +: 32]);
    end

    // Isolate the lowest set bit so overlapping windows resolve to the
    // lowest slave index.
    assign sel_o = match & (~match + NUM_SLV'(1));
    assign hit_o = |match;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge -- single-master to NUM_SLV-slave MMIO bridge.
//   clk_from_cpu / rst_from_cpu : clock, asynchronous active-high reset
//   req/addr/we/wdata_from_cpu  : CPU request, sampled in IDLE only
//   ack/err/rdata_to_cpu        : one-cycle completion pulse with status/data
//   req_to_slv                  : one-hot slave request, held until ack/timeout
//   addr/we/wdata_to_slv        : latched request fields shared by all slaves
//   ack_from_slv/rdata_from_slv : per-slave completion and read data
// Optional feature macro: BRIDGE_ERR_REG_EN adds an internal error register at
// ERR_REG_ADDR holding {sticky flag, last faulting addr[30:0]}; reads return
// it, any write clears it. Without the macro that address decodes normally.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                     NUM_SLV  = 5,
    parameter int                     DATA_W   = 32,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE = '0,
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK = '0,
    parameter int                     TIMEOUT  = 15
) (
    input  logic                      clk_from_cpu,
    input  logic                      rst_from_cpu,
    input  logic                      req_from_cpu,
    input  logic [31:0]               addr_from_cpu,
    input  logic                      we_from_cpu,
    input  logic [DATA_W-1:0]         wdata_from_cpu,
    output logic                      ack_to_cpu,
    output logic                      err_to_cpu,
    output logic [DATA_W-1:0]         rdata_to_cpu,
    output logic [NUM_SLV-1:0]        req_to_slv,
    output logic [31:0]               addr_to_slv,
    output logic                      we_to_slv,
    output logic [DATA_W-1:0]         wdata_to_slv,
    input  logic [NUM_SLV-1:0]        ack_from_slv,
    input  logic [NUM_SLV*DATA_W-1:0] rdata_from_slv
);

    localparam int                REP      = (DATA_W + 31) / 32;
    localparam logic [REP*32-1:0] ERR_REP  = {REP{ERR_DATA}};
    localparam logic [DATA_W-1:0] ERR_FILL = ERR_REP[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q;
    logic [NUM_SLV-1:0]  req_q;
    logic [31:0]         addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ack_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
`ifdef BRIDGE_ERR_REG_EN
    logic                reg_acc_q;
    logic [31:0]         err_reg_q;
`endif

    logic [NUM_SLV-1:0]  dec_sel_d;
    logic                dec_hit_d;
    logic                slv_ack_d;
    logic [DATA_W-1:0]   slv_rdata_d;

    mmio_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i (addr_from_cpu),
        .sel_o  (dec_sel_d),
        .hit_o  (dec_hit_d)
    );

    // req_q is zero outside ACCESS, so masking with it drops acks from
    // non-selected slaves and any ack arriving in IDLE/RESP.
    assign slv_ack_d = |(ack_from_slv & req_q);

    always_comb begin
        slv_rdata_d = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (req_q[i]) slv_rdata_d = slv_rdata_d | rdata_from_slv[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_from_cpu or posedge rst_from_cpu) begin
        if (rst_from_cpu) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef BRIDGE_ERR_REG_EN
            reg_acc_q <= 1'b0;
            err_reg_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_from_cpu) begin
                        addr_q  <= addr_from_cpu;
                        we_q    <= we_from_cpu;
                        wdata_q <= wdata_from_cpu;
                        cnt_q   <= '0;
`ifdef BRIDGE_ERR_REG_EN
                        // Register access spends one ACCESS cycle with no
                        // slave request so its latency matches a slave hit.
                        if (addr_from_cpu == ERR_REG_ADDR) begin
                            reg_acc_q <= 1'b1;
                            state_q   <= ST_ACCESS;
                        end else
`endif
                        if (dec_hit_d) begin
                            req_q   <= dec_sel_d;
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= ERR_FILL;
`ifdef BRIDGE_ERR_REG_EN
                            err_reg_q <= {1'b1, addr_from_cpu[30:0]};
`endif
                        end
                    end
                end
                ST_ACCESS: begin
`ifdef BRIDGE_ERR_REG_EN
                    if (reg_acc_q) begin
                        reg_acc_q <= 1'b0;
                        state_q   <= ST_RESP;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b0;
                        rdata_q   <= DATA_W'(err_reg_q);
                        if (we_q) err_reg_q <= '0;
                    end else
`endif
                    // An ack in the last allowed cycle still wins over timeout.
                    if (slv_ack_d) begin
                        req_q   <= '0;
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= slv_rdata_d;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= '0;
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_FILL;
`ifdef BRIDGE_ERR_REG_EN
                        err_reg_q <= {1'b1, addr_q[30:0]};
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_to_cpu   = ack_q;
    assign err_to_cpu   = err_q;
    assign rdata_to_cpu = rdata_q;
    assign req_to_slv   = req_q;
    assign addr_to_slv  = addr_q;
    assign we_to_slv    = we_q;
    assign wdata_to_slv = wdata_q;

endmodule
